// File: rtl/mem_master_pkg.sv
// Shared definitions for the two-port memory master: FSM state encoding,
// requester port identifiers and a small port helper.
package mem_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // Requester identifiers; also used as the bit index into the request vector.
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // The port that is not p.
   function automatic logic other_port(input logic p);
      return ~p;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie the port that was not granted last
// wins; after reset the last grant is B, so A wins the first tie.
module rr_arbiter2
   import mem_master_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant
);

   logic last_q;
   logic last_d;

   // Grant selection: single requester wins outright, tie goes to the other port.
   always_comb begin
      grant = PORT_A;
      if (req[PORT_A] && req[PORT_B]) begin
         grant = other_port(last_q);
      end else if (req[PORT_B]) begin
         grant = PORT_B;
      end
   end

   // Last-grant update when the consumer accepts the current grant.
   always_comb begin
      last_d = last_q;
      if (advance) begin
         last_d = grant;
      end
   end

   // Last-grant register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_master.sv
// Two-port memory master. Arbitrates between port A (CPU data) and port B
// (player-input peripheral), runs one single-cycle memory strobe per
// transaction and returns the result with a four-phase req/ack handshake.
module mem_master
   import mem_master_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int RAM_ADDR_BITS = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     a_req,
   input  logic                     a_we,
   input  logic [RAM_ADDR_BITS-1:0] a_adr,
   input  logic [WIDTH-1:0]         a_wdata,
   output logic                     a_ack,
   output logic [WIDTH-1:0]         a_rdata,
   input  logic                     b_req,
   input  logic                     b_we,
   input  logic [RAM_ADDR_BITS-1:0] b_adr,
   input  logic [WIDTH-1:0]         b_wdata,
   output logic                     b_ack,
   output logic [WIDTH-1:0]         b_rdata,
   output logic                     mem_en,
   output logic                     mem_write,
   output logic                     mem_read,
   output logic [RAM_ADDR_BITS-1:0] mem_adr,
   output logic [WIDTH-1:0]         mem_wdata,
   input  logic [WIDTH-1:0]         mem_rdata,
   output logic                     busy
);

   state_e                   state_q,     state_d;
   logic                     gnt_q,       gnt_d;
   logic                     a_ack_q,     a_ack_d;
   logic                     b_ack_q,     b_ack_d;
   logic [WIDTH-1:0]         a_rdata_q,   a_rdata_d;
   logic [WIDTH-1:0]         b_rdata_q,   b_rdata_d;
   logic                     mem_en_q,    mem_en_d;
   logic                     mem_write_q, mem_write_d;
   logic                     mem_read_q,  mem_read_d;
   logic [RAM_ADDR_BITS-1:0] mem_adr_q,   mem_adr_d;
   logic [WIDTH-1:0]         mem_wdata_q, mem_wdata_d;

   logic                     arb_grant;
   logic                     arb_advance;
   logic                     sel_we;
   logic [RAM_ADDR_BITS-1:0] sel_adr;
   logic [WIDTH-1:0]         sel_wdata;
   logic                     cur_req;
   logic                     cur_ack;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({b_req, a_req}),
      .advance (arb_advance),
      .grant   (arb_grant)
   );

   // Request fields of the port the arbiter is currently offering.
   always_comb begin
      sel_we    = a_we;
      sel_adr   = a_adr;
      sel_wdata = a_wdata;
      if (arb_grant == PORT_B) begin
         sel_we    = b_we;
         sel_adr   = b_adr;
         sel_wdata = b_wdata;
      end
   end

   // Handshake signals of the port that owns the in-flight transaction.
   always_comb begin
      cur_req = a_req;
      cur_ack = a_ack_q;
      if (gnt_q == PORT_B) begin
         cur_req = b_req;
         cur_ack = b_ack_q;
      end
   end

   // Next-state and registered-output logic.
   // RESP always spends its first cycle with ack low and raises ack on the
   // next edge; ack then stays up until the owner's req is seen low. This
   // gives the 2/3-cycle latencies and makes a req that is already gone
   // produce exactly a one-cycle ack pulse.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      a_ack_d     = a_ack_q;
      b_ack_d     = b_ack_q;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      mem_en_d    = 1'b0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_adr_d   = mem_adr_q;
      mem_wdata_d = mem_wdata_q;
      arb_advance = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (a_req || b_req) begin
               arb_advance = 1'b1;
               gnt_d       = arb_grant;
               mem_en_d    = 1'b1;
               mem_write_d = sel_we;
               mem_read_d  = ~sel_we;
               mem_adr_d   = sel_adr;
               mem_wdata_d = sel_wdata;
               state_d     = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            state_d = mem_write_q ? ST_RESP : ST_WAIT;
         end

         ST_WAIT: begin
            if (gnt_q == PORT_B) begin
               b_rdata_d = mem_rdata;
            end else begin
               a_rdata_d = mem_rdata;
            end
            state_d = ST_RESP;
         end

         ST_RESP: begin
            if (!cur_ack) begin
               if (gnt_q == PORT_B) begin
                  b_ack_d = 1'b1;
               end else begin
                  a_ack_d = 1'b1;
               end
            end else if (!cur_req) begin
               a_ack_d = 1'b0;
               b_ack_d = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= PORT_A;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_adr_q   <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_write_q <= mem_write_d;
         mem_read_q  <= mem_read_d;
         mem_adr_q   <= mem_adr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_write = mem_write_q;
   assign mem_read  = mem_read_q;
   assign mem_adr   = mem_adr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: a behavioural RAM, per-port requester
// tasks and a scoreboard of expected transactions in predicted grant order.
module tb_mem_master;

   localparam int W  = 16;
   localparam int AB = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req, a_we, b_req, b_we;
   logic [AB-1:0] a_adr, b_adr;
   logic [W-1:0]  a_wdata, b_wdata;
   logic          a_ack, b_ack;
   logic [W-1:0]  a_rdata, b_rdata;
   logic          mem_en, mem_write, mem_read;
   logic [AB-1:0] mem_adr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata;
   logic          busy;

   mem_master #(.WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_write(mem_write), .mem_read(mem_read),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural RAM: write on the strobe edge, read data registered on it.
   logic [W-1:0] ram     [0:65535];
   logic [W-1:0] ref_mem [0:65535];
   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      mem_rdata = '0;
   end
   always @(posedge clk) begin
      if (mem_en && mem_write) ram[mem_adr] <= mem_wdata;
      if (mem_en && mem_read)  mem_rdata    <= ram[mem_adr];
   end

   typedef struct {
      logic          port;
      logic          we;
      logic [AB-1:0] adr;
      logic [W-1:0]  wdata;
      logic [W-1:0]  rdata;
   } txn_t;
   txn_t sb[$];
   logic [W-1:0] exp_rd [2];

   // Queue an expected transaction; must be called in predicted grant order.
   task automatic push_exp(input logic p, input logic we, input logic [AB-1:0] adr,
                           input logic [W-1:0] wd);
      txn_t t;
      t.port  = p;
      t.we    = we;
      t.adr   = adr;
      t.wdata = wd;
      t.rdata = ref_mem[adr];
      if (we) ref_mem[adr] = wd;
      sb.push_back(t);
   endtask

   // Monitor: strobe contents, one-cycle mem_en, ack ordering and rdata.
   logic en_prev = 1'b0, a_prev = 1'b0, b_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         en_prev = 1'b0;
         a_prev  = 1'b0;
         b_prev  = 1'b0;
      end else begin
         check_eq("ack_excl", {31'd0, a_ack & b_ack}, 32'd0);
         if (mem_en) begin
            check_eq("mem_en_pulse", {31'd0, en_prev}, 32'd0);
            check_eq("mem_sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               check_eq("mem_adr",   {16'd0, mem_adr}, {16'd0, sb[0].adr});
               check_eq("mem_write", {31'd0, mem_write}, {31'd0, sb[0].we});
               check_eq("mem_read",  {31'd0, mem_read}, {31'd0, !sb[0].we});
               if (sb[0].we) check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, sb[0].wdata});
            end
         end
         if ((a_ack && !a_prev) || (b_ack && !b_prev)) begin
            logic p;
            txn_t t;
            p = b_ack && !b_prev;
            check_eq("ack_sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               t = sb.pop_front();
               check_eq("ack_port", {31'd0, p}, {31'd0, t.port});
               if (!t.we) exp_rd[p] = t.rdata;
               check_eq(p ? "b_rdata" : "a_rdata", {16'd0, p ? b_rdata : a_rdata}, {16'd0, exp_rd[p]});
               check_eq(p ? "a_rdata_hold" : "b_rdata_hold", {16'd0, p ? a_rdata : b_rdata},
                        {16'd0, exp_rd[!p]});
            end
         end
         en_prev = mem_en;
         a_prev  = a_ack;
         b_prev  = b_ack;
      end
   end

   function automatic logic ack_of(input logic p);
      return p ? b_ack : a_ack;
   endfunction

   task automatic set_port(input logic p, input logic req, input logic we,
                           input logic [AB-1:0] adr, input logic [W-1:0] wd);
      if (p) begin
         b_req = req; b_we = we; b_adr = adr; b_wdata = wd;
      end else begin
         a_req = req; a_we = we; a_adr = adr; a_wdata = wd;
      end
   endtask

   // One four-phase transaction on port p. lat = edges from first req sample to ack high.
   task automatic run_txn(input logic p, input logic we, input logic [AB-1:0] adr,
                          input logic [W-1:0] wd, input bit drop_early, input bit wiggle,
                          output int lat);
      int  cyc;
      bit  got;
      cyc = 0;
      got = 1'b0;
      set_port(p, 1'b1, we, adr, wd);
      while (cyc < 60 && !got) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1 && drop_early) set_port(p, 1'b0, we, adr, wd);
         if (cyc == 1 && wiggle)     set_port(p, !drop_early, we, ~adr, ~wd);
         if (ack_of(p)) got = 1'b1;
      end
      check_eq("ack_seen", {31'd0, got}, 32'd1);
      lat = cyc - 1;
      set_port(p, 1'b0, we, adr, wd);
      @(posedge clk); #1;
      check_eq("ack_fall", {31'd0, ack_of(p)}, 32'd0);
   endtask

   int lat, lat_b;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      a_req = 0; a_we = 0; a_adr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_adr = '0; b_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy",    {31'd0, busy}, 32'd0);
      check_eq("rst_mem_en",  {29'd0, mem_en, mem_write, mem_read}, 32'd0);
      check_eq("rst_mem_adr", {mem_adr, mem_wdata}, 32'd0);
      check_eq("rst_ack",     {30'd0, a_ack, b_ack}, 32'd0);
      check_eq("rst_rdata",   {a_rdata, b_rdata}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First tie after reset: A, then B.
      push_exp(1'b0, 1'b1, 16'h0100, 16'h1111);
      push_exp(1'b1, 1'b1, 16'h0200, 16'h2222);
      fork
         run_txn(1'b0, 1'b1, 16'h0100, 16'h1111, 0, 0, lat);
         run_txn(1'b1, 1'b1, 16'h0200, 16'h2222, 0, 0, lat_b);
      join
      check_eq("tie1_a_lat", lat, 32'd2);

      // Write then read back 0x0010.
      push_exp(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      run_txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 0, lat);
      check_eq("wr_lat", lat, 32'd2);
      push_exp(1'b0, 1'b0, 16'h0010, '0);
      run_txn(1'b0, 1'b0, 16'h0010, '0, 0, 0, lat);
      check_eq("rd_lat", lat, 32'd3);
      check_eq("rd_beef", {16'd0, a_rdata}, 32'h0000BEEF);

      // Last grant was A, so B wins this tie.
      push_exp(1'b1, 1'b0, 16'h0100, '0);
      push_exp(1'b0, 1'b0, 16'h0200, '0);
      fork
         run_txn(1'b0, 1'b0, 16'h0200, '0, 0, 0, lat);
         run_txn(1'b1, 1'b0, 16'h0100, '0, 0, 0, lat_b);
      join
      check_eq("tie2_b_lat", lat_b, 32'd3);

      // req dropped before RESP: one-cycle ack pulse.
      push_exp(1'b1, 1'b1, 16'h0300, 16'h3333);
      run_txn(1'b1, 1'b1, 16'h0300, 16'h3333, 1, 0, lat);
      check_eq("drop_wr_lat", lat, 32'd2);
      push_exp(1'b0, 1'b0, 16'h0300, '0);
      run_txn(1'b0, 1'b0, 16'h0300, '0, 1, 0, lat);
      check_eq("drop_rd_lat", lat, 32'd3);

      // Address/data change after grant must not reach the memory.
      push_exp(1'b0, 1'b1, 16'h0400, 16'h4444);
      run_txn(1'b0, 1'b1, 16'h0400, 16'h4444, 0, 1, lat);
      push_exp(1'b0, 1'b0, 16'h0400, '0);
      run_txn(1'b0, 1'b0, 16'h0400, '0, 0, 0, lat);
      push_exp(1'b1, 1'b0, 16'hFBFF, '0);
      run_txn(1'b1, 1'b0, 16'hFBFF, '0, 0, 0, lat);

      // Address range extremes.
      push_exp(1'b1, 1'b1, 16'hFFFF, 16'hA5A5);
      run_txn(1'b1, 1'b1, 16'hFFFF, 16'hA5A5, 0, 0, lat);
      push_exp(1'b1, 1'b1, 16'h0000, 16'h5A5A);
      run_txn(1'b1, 1'b1, 16'h0000, 16'h5A5A, 0, 0, lat);
      push_exp(1'b1, 1'b0, 16'hFFFF, '0);
      run_txn(1'b1, 1'b0, 16'hFFFF, '0, 0, 0, lat);
      push_exp(1'b0, 1'b0, 16'h0000, '0);
      run_txn(1'b0, 1'b0, 16'h0000, '0, 0, 0, lat);

      // Reset in ACCESS of a read aborts it with no ack.
      push_exp(1'b0, 1'b0, 16'h0010, '0);
      set_port(1'b0, 1'b1, 1'b0, 16'h0010, '0);
      @(posedge clk); #1;
      check_eq("abort_acc_en", {31'd0, mem_en}, 32'd1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_eq("abort_mem_en", {31'd0, mem_en}, 32'd0);
      check_eq("abort_busy",   {31'd0, busy}, 32'd0);
      set_port(1'b0, 1'b0, 1'b0, 16'h0010, '0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("abort_ack",   {30'd0, a_ack, b_ack}, 32'd0);
      check_eq("abort_rdata", {a_rdata, b_rdata}, 32'd0);
      sb.delete();
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_exp(1'b0, 1'b0, 16'h0010, '0);
      run_txn(1'b0, 1'b0, 16'h0010, '0, 0, 0, lat);
      check_eq("post_rst_lat", lat, 32'd3);
      check_eq("post_rst_rd",  {16'd0, a_rdata}, 32'h0000BEEF);

      // Random single-port traffic over a small address window.
      for (int k = 0; k < 12; k++) begin
         logic          p, we;
         logic [AB-1:0] adr;
         logic [W-1:0]  wd;
         p   = 1'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         adr = 16'h0800 + 16'($urandom_range(0, 3));
         wd  = 16'($urandom);
         push_exp(p, we, adr, wd);
         run_txn(p, we, adr, wd, 0, 0, lat);
         check_eq("rand_lat", lat, we ? 32'd2 : 32'd3);
      end

      repeat (3) @(posedge clk);
      #1;
      check_eq("sb_drained", sb.size(), 32'd0);
      check_eq("end_idle",   {31'd0, busy}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 16, memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a_req/a_we  input  1 each  port A (CPU data) request / write-select.
REQ-006 SHALL have ports a_adr  input  RAM_ADDR_BITS, a_wdata  input  WIDTH  port A address / write data.
REQ-007 SHALL have ports a_ack  output  1, a_rdata  output  WIDTH  port A acknowledge / read data.
REQ-008 SHALL have ports b_req, b_we, b_adr, b_wdata, b_ack, b_rdata with the same widths and meaning for port B (player-input peripheral).
REQ-009 SHALL have ports mem_en, mem_write, mem_read  output  1 each  memory enable / write / read strobes.
REQ-010 SHALL have ports mem_adr  output  RAM_ADDR_BITS, mem_wdata  output  WIDTH  memory address / write data.
REQ-011 SHALL have port mem_rdata  input  WIDTH  memory read data, registered by memory on the edge that samples mem_en&mem_read.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, ACCESS, WAIT, RESP.
REQ-014 IDLE: on any req high, SHALL grant one port, register its we/adr/wdata into mem_* and go to ACCESS; else stay.
REQ-015 Both req high in same IDLE cycle: SHALL grant round-robin (port not granted last); after reset port A wins first tie.
REQ-016 ACCESS: SHALL hold mem_en=1 and exactly one of mem_write/mem_read=1 for exactly one cycle; write -> RESP, read -> WAIT.
REQ-017 WAIT: mem_en=0; SHALL capture mem_rdata into granted port's rdata at end of cycle; -> RESP.
REQ-018 RESP: SHALL assert granted port's ack while its req is high; on req low SHALL drop ack and go to IDLE (four-phase handshake).
REQ-019 If req already low on entering RESP, ack SHALL pulse for exactly one cycle, then IDLE.
REQ-020 Latency from req sampled in IDLE to ack high SHALL be 2 cycles for writes, 3 for reads.
REQ-021 Requester SHALL hold we/adr/wdata stable until ack; changes after grant SHALL NOT affect the in-flight access.
REQ-022 Non-granted port's ack SHALL stay 0; its rdata SHALL hold its last value.
REQ-023 Addresses SHALL pass unmodified (no offset, no wrap logic); full RAM_ADDR_BITS range legal.
REQ-024 mem_* outputs and ack SHALL be registered (no combinational req-to-mem path).
REQ-025 mem_en SHALL be 0 in IDLE, WAIT and RESP.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, mem_en/mem_write/mem_read=0, mem_adr/mem_wdata=0, a_ack/b_ack=0, a_rdata/b_rdata=0, busy=0, last-grant=B.
REQ-027 Reset mid-transaction SHALL abort it with no ack; a memory write already strobed is not undone.

Structure
REQ-028 Package mem_master_pkg SHALL hold state encoding and port-ID constants (PORT_A, PORT_B).
REQ-029 Two-way round-robin grant SHALL be sub-module rr_arbiter2 (req[1:0], advance, grant).

Verification
REQ-030 A write adr=16'h0010 data=16'hBEEF -> mem_en&mem_write one cycle with those values; a_ack high 2 cycles after req.
REQ-031 A read adr=16'h0010 after REQ-030 -> a_rdata=16'hBEEF when a_ack rises, 3 cycles after req.
REQ-032 a_req and b_req rise together twice -> first grant A, second grant B; b_ack never overlaps a_ack.
REQ-033 rst_n low in ACCESS of a read -> mem_en=0 and busy=0 immediately; no ack; next request serviced normally.
REQ-034 req dropped before RESP -> ack one-cycle pulse; adr change after grant -> mem_adr keeps granted value.
